ram_arbiter: RTL and testbench

- Round-robin arbiter that shares one external word-wide RAM port between NUM_PORTS cache controllers (e.g. I-cache and D-cache).
- Each controller issues line bursts of 2**WORD_OFFSET_WIDTH beats: writeback or fetch.
- The arbiter latches single-cycle command pulses and grants one requester per burst.
- It locks the grant until the last beat completes and steers ram_data_valid/ram_data_rd back only to the owner.

---
 rtl/ram_arb_pkg.sv | 12 +
 rtl/rr_picker.sv | 23 ++
 rtl/ram_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the cache-to-RAM round-robin arbiter.
package ram_arb_pkg;

    typedef enum logic {IDLE, BURST} arb_state_t;

    localparam int DATA_WIDTH = 32;

    function automatic int beats(input int word_offset_width);
        return 1 << word_offset_width;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_PORTS-1:0] winner,
    output logic                 valid
);

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!valid && req[(int'(ptr) + k) % NUM_PORTS]) begin
                winner[(int'(ptr) + k) % NUM_PORTS] = 1'b1;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one word-wide RAM port between NUM_PORTS cache controllers; the grant
// is held for a whole line burst and RAM completions are steered to the owner.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_PORTS         = 2,
    parameter int ADDRESS_WIDTH     = 16,
    parameter int WORD_OFFSET_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS-1:0]             req_rd,
    input  logic [NUM_PORTS-1:0]             req_wr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_data_wr,
    output logic [NUM_PORTS-1:0]             req_data_valid,
    output logic [DATA_WIDTH-1:0]            req_data_rd,
    output logic [NUM_PORTS-1:0]             grant,
    output logic [ADDRESS_WIDTH-1:0]         ram_address,
    output logic                             ram_rd,
    output logic                             ram_wr,
    output logic [DATA_WIDTH-1:0]            ram_data_wr,
    input  logic [DATA_WIDTH-1:0]            ram_data_rd,
    input  logic                             ram_data_valid
);

    localparam int PW    = $clog2(NUM_PORTS);
    localparam int BEATS = beats(WORD_OFFSET_WIDTH);
    localparam logic [WORD_OFFSET_WIDTH-1:0] LAST_BEAT = WORD_OFFSET_WIDTH'(BEATS - 1);

    arb_state_t                   state;
    logic [NUM_PORTS-1:0]         pending;
    logic [NUM_PORTS-1:0]         pend_wr;
    logic [PW-1:0]                owner;
    logic [PW-1:0]                rr_ptr;
    logic [WORD_OFFSET_WIDTH-1:0] beat_cnt;

    logic [NUM_PORTS-1:0] cmd;
    logic [NUM_PORTS-1:0] req_vec;
    logic [NUM_PORTS-1:0] win_onehot;
    logic                 win_valid;
    logic [PW-1:0]        win_idx;
    logic [NUM_PORTS-1:0] eff_wr;
    logic [NUM_PORTS-1:0] cap_mask;
    logic                 last_beat;

    assign cmd     = req_rd | req_wr;
    assign req_vec = pending | cmd;

    rr_picker #(.NUM_PORTS(NUM_PORTS), .PTR_WIDTH(PW)) u_picker (
        .req    (req_vec),
        .ptr    (rr_ptr),
        .winner (win_onehot),
        .valid  (win_valid)
    );

    // A fresh command this cycle decides the op; otherwise the latched one does.
    always_comb begin
        win_idx = '0;
        eff_wr  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (win_onehot[i]) win_idx = PW'(i);
            eff_wr[i] = cmd[i] ? req_wr[i] : pend_wr[i];
        end
    end

    assign last_beat = (state == BURST) && ram_data_valid && (beat_cnt == LAST_BEAT);

    // The owner's own commands are only latched on its final beat.
    assign cap_mask = ((state == BURST) && !last_beat) ? ~grant : '1;

    assign req_data_valid = (state == BURST) ? (grant & {NUM_PORTS{ram_data_valid}}) : '0;
    assign req_data_rd    = ram_data_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= '0;
            pend_wr     <= '0;
            grant       <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            ram_address <= '0;
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
            ram_data_wr <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (cap_mask[i] && cmd[i]) begin
                    pending[i] <= 1'b1;
                    pend_wr[i] <= req_wr[i];
                end
            end

            case (state)
                IDLE: begin
                    ram_rd <= 1'b0;
                    ram_wr <= 1'b0;
                    if (win_valid) begin
                        state             <= BURST;
                        grant             <= win_onehot;
                        owner             <= win_idx;
                        beat_cnt          <= '0;
                        ram_address       <= req_address[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        ram_data_wr       <= req_data_wr[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        ram_rd            <= ~eff_wr[win_idx];
                        ram_wr            <= eff_wr[win_idx];
                        pending[win_idx]  <= 1'b0;
                        pend_wr[win_idx]  <= 1'b0;
                    end
                end
                BURST: begin
                    ram_address <= req_address[owner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    ram_data_wr <= req_data_wr[owner*DATA_WIDTH +: DATA_WIDTH];
                    ram_rd      <= req_rd[owner];
                    ram_wr      <= req_wr[owner];
                    if (ram_data_valid) beat_cnt <= beat_cnt + 1'b1;
                    if (last_beat) begin
                        state  <= IDLE;
                        grant  <= '0;
                        rr_ptr <= (owner == PW'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
                        ram_rd <= 1'b0;
                        ram_wr <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with two ports and four-beat bursts.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_address;
    logic [1:0]  req_rd;
    logic [1:0]  req_wr;
    logic [63:0] req_data_wr;
    logic [1:0]  req_data_valid;
    logic [31:0] req_data_rd;
    logic [1:0]  grant;
    logic [15:0] ram_address;
    logic        ram_rd;
    logic        ram_wr;
    logic [31:0] ram_data_wr;
    logic [31:0] ram_data_rd;
    logic        ram_data_valid;

    int vectors     = 0;
    int miscompares = 0;

    logic [1:0] fair_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    ram_arbiter #(.NUM_PORTS(2), .ADDRESS_WIDTH(16), .WORD_OFFSET_WIDTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_address    (req_address),
        .req_rd         (req_rd),
        .req_wr         (req_wr),
        .req_data_wr    (req_data_wr),
        .req_data_valid (req_data_valid),
        .req_data_rd    (req_data_rd),
        .grant          (grant),
        .ram_address    (ram_address),
        .ram_rd         (ram_rd),
        .ram_wr         (ram_wr),
        .ram_data_wr    (ram_data_wr),
        .ram_data_rd    (ram_data_rd),
        .ram_data_valid (ram_data_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One RAM completion: the owner sees it combinationally in the same cycle.
    task automatic beat(input string tag, input logic [31:0] d, input logic [1:0] exp_v);
        ram_data_valid = 1'b1;
        ram_data_rd    = d;
        #1;
        check({tag, " valid"}, req_data_valid, exp_v);
        check({tag, " rdata"}, req_data_rd, d);
        @(posedge clk);
        #1;
        ram_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        req_address    = '0;
        req_rd         = '0;
        req_wr         = '0;
        req_data_wr    = '0;
        ram_data_rd    = '0;
        ram_data_valid = 1'b0;
        do_reset();

        check("rst grant", grant, 2'b00);
        check("rst ram_rd", ram_rd, 1'b0);
        check("rst ram_wr", ram_wr, 1'b0);
        check("rst ram_address", ram_address, 16'h0000);
        check("rst ram_data_wr", ram_data_wr, 32'h0);
        check("rst req_data_valid", req_data_valid, 2'b00);

        // single read from port0
        req_address = {16'h0000, 16'h0040};
        req_rd      = 2'b01;
        tick();
        req_rd = 2'b00;
        check("rd1 ram_rd", ram_rd, 1'b1);
        check("rd1 ram_wr", ram_wr, 1'b0);
        check("rd1 ram_address", ram_address, 16'h0040);
        check("rd1 grant", grant, 2'b01);
        beat("rd1 b0", 32'hA0, 2'b01);
        check("rd1 ram_rd after cmd", ram_rd, 1'b0);
        beat("rd1 b1", 32'hA1, 2'b01);
        beat("rd1 b2", 32'hA2, 2'b01);
        beat("rd1 b3", 32'hA3, 2'b01);
        check("rd1 grant end", grant, 2'b00);
        check("rd1 ram_rd end", ram_rd, 1'b0);

        // simultaneous read on port0 and write on port1 after reset
        do_reset();
        req_address = {16'h0200, 16'h0100};
        req_data_wr = {32'hDEADBEEF, 32'h0};
        req_rd      = 2'b01;
        req_wr      = 2'b10;
        tick();
        req_rd = 2'b00;
        req_wr = 2'b00;
        check("sim p0 grant", grant, 2'b01);
        check("sim p0 ram_rd", ram_rd, 1'b1);
        check("sim p0 ram_address", ram_address, 16'h0100);
        beat("sim p0 b0", 32'hB0, 2'b01);
        beat("sim p0 b1", 32'hB1, 2'b01);
        beat("sim p0 b2", 32'hB2, 2'b01);
        beat("sim p0 b3", 32'hB3, 2'b01);
        check("sim gap grant", grant, 2'b00);
        tick();
        check("sim p1 grant", grant, 2'b10);
        check("sim p1 ram_wr", ram_wr, 1'b1);
        check("sim p1 ram_rd", ram_rd, 1'b0);
        check("sim p1 ram_address", ram_address, 16'h0200);
        check("sim p1 ram_data_wr", ram_data_wr, 32'hDEADBEEF);
        for (int b = 0; b < 4; b++) beat("sim p1 beat", 32'hC0 + b, 2'b10);
        check("sim p1 grant end", grant, 2'b00);

        // fairness: both ports request continuously
        req_address = {16'h0500, 16'h0400};
        req_rd      = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("fair grant", grant, fair_exp[k]);
            for (int b = 0; b < 4; b++) beat("fair beat", 32'h100 + b, fair_exp[k]);
            check("fair grant end", grant, 2'b00);
        end
        req_rd = 2'b00;

        // late arrival of port1 during port0's second beat
        do_reset();
        req_address = {16'h0080, 16'h0040};
        req_rd      = 2'b01;
        tick();
        req_rd = 2'b00;
        check("late p0 grant", grant, 2'b01);
        beat("late b0", 32'hD0, 2'b01);
        req_rd = 2'b10;
        beat("late b1", 32'hD1, 2'b01);
        req_rd = 2'b00;
        beat("late b2", 32'hD2, 2'b01);
        beat("late b3", 32'hD3, 2'b01);
        check("late gap grant", grant, 2'b00);
        tick();
        check("late p1 grant", grant, 2'b10);
        check("late p1 ram_rd", ram_rd, 1'b1);
        check("late p1 ram_address", ram_address, 16'h0080);
        for (int b = 0; b < 4; b++) beat("late p1 beat", 32'hE0 + b, 2'b10);
        check("late p1 grant end", grant, 2'b00);

        // stray valid while idle must not reach anyone or advance the count
        beat("stray", 32'hEE, 2'b00);
        tick();
        check("stray grant", grant, 2'b00);
        check("stray ram_rd", ram_rd, 1'b0);
        req_rd = 2'b01;
        tick();
        req_rd = 2'b00;
        check("post-stray grant", grant, 2'b01);
        beat("post-stray b0", 32'hF0, 2'b01);
        beat("post-stray b1", 32'hF1, 2'b01);
        beat("post-stray b2", 32'hF2, 2'b01);
        check("post-stray held after 3", grant, 2'b01);
        beat("post-stray b3", 32'hF3, 2'b01);
        check("post-stray grant end", grant, 2'b00);

        // reset in the middle of a burst with port1 pending
        req_address = {16'h0300, 16'h0040};
        req_data_wr = {32'h12345678, 32'h0};
        req_rd      = 2'b01;
        tick();
        req_rd = 2'b00;
        check("mid p0 grant", grant, 2'b01);
        req_wr = 2'b10;
        beat("mid b0", 32'h11, 2'b01);
        req_wr = 2'b00;
        rst    = 1'b1;
        tick();
        check("mid rst grant", grant, 2'b00);
        check("mid rst ram_rd", ram_rd, 1'b0);
        check("mid rst ram_wr", ram_wr, 1'b0);
        check("mid rst ram_address", ram_address, 16'h0000);
        check("mid rst ram_data_wr", ram_data_wr, 32'h0);
        check("mid rst req_data_valid", req_data_valid, 2'b00);
        rst = 1'b0;
        tick();
        tick();
        check("mid pending cleared", grant, 2'b00);
        req_rd = 2'b10;
        tick();
        req_rd = 2'b00;
        check("mid fresh grant", grant, 2'b10);
        check("mid fresh ram_rd", ram_rd, 1'b1);
        check("mid fresh ram_address", ram_address, 16'h0300);
        for (int b = 0; b < 4; b++) beat("mid fresh beat", 32'h200 + b, 2'b10);
        check("mid fresh grant end", grant, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
